// File: rtl/branch_pkg.sv
// Shared branch-condition codes, counter type and BHT index helper for the
// branch predict/resolve block.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int BHT_CNT_W = 2;
  typedef logic [BHT_CNT_W-1:0] bht_cnt_t;

  // Word-aligned PC: drop the byte offset; callers truncate to their index width.
  function automatic logic [31:0] bht_idx(input logic [31:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/bht_counter_array.sv
// Bimodal history table: one combinational read port returning the predicted
// direction, one saturating update port, synchronous reset of every entry.
module bht_counter_array #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  logic [CNT_W-1:0] r_cnt [ENTRIES];

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                input logic up);
    if (up)
      return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    else
      return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

  // Table update stage: reset lands every entry at weakly not-taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++)
        r_cnt[i] <= CNT_W'(1);
    end else if (i_upd_en) begin
      r_cnt[i_upd_idx] <= sat_step(r_cnt[i_upd_idx], i_upd_taken);
    end
  end

  assign o_rd_taken = r_cnt[i_rd_idx][CNT_W-1];

endmodule

// File: rtl/branch_predict_resolve.sv
// RV32I branch/jump resolution: full-operand condition evaluation, bimodal
// prediction lookup, registered mispredict flush and saturating perf counters.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 2,
  parameter int PERF_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_pf_pc,
  output logic              o_pf_taken,
  input  logic              i_ex_valid,
  input  logic              i_ex_branch,
  input  logic              i_ex_jump,
  input  logic [2:0]        i_ex_funct3,
  input  logic [XLEN-1:0]   i_ex_rs1,
  input  logic [XLEN-1:0]   i_ex_rs2,
  input  logic [XLEN-1:0]   i_ex_pc,
  input  logic              i_ex_pred_taken,
  output logic              o_taken,
  output logic              o_flush,
  output logic              o_flush_taken,
  output logic              o_illegal_br,
  output logic [PERF_W-1:0] o_br_count,
  output logic [PERF_W-1:0] o_mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic                   w_vld_p0;
  logic                   w_br_p0;
  logic                   w_illegal_p0;
  logic                   w_taken_p0;
  logic                   w_mispred_p0;
  logic signed [XLEN-1:0] w_rs1_s;
  logic signed [XLEN-1:0] w_rs2_s;
  logic [IDX_W-1:0]       w_pf_idx;
  logic [IDX_W-1:0]       w_ex_idx;

  logic                   r_flush_p1;
  logic                   r_flush_taken_p1;
  logic                   r_illegal_p1;
  logic [PERF_W-1:0]      r_br_count_p1;
  logic [PERF_W-1:0]      r_mispred_count_p1;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt,
                                                input logic en);
    return (en && cnt != {PERF_W{1'b1}}) ? cnt + 1'b1 : cnt;
  endfunction

  assign w_vld_p0     = i_ex_valid & (i_ex_branch | i_ex_jump);
  assign w_br_p0      = w_vld_p0 & i_ex_branch;
  assign w_illegal_p0 = w_br_p0 & (i_ex_funct3[2:1] == 2'b01);
  assign w_rs1_s      = i_ex_rs1;
  assign w_rs2_s      = i_ex_rs2;

  // Branch wins over jump when both flags are set
  always_comb begin
    w_taken_p0 = 1'b0;
    if (w_br_p0) begin
      case (i_ex_funct3)
        F3_BEQ:  w_taken_p0 = (i_ex_rs1 == i_ex_rs2);
        F3_BNE:  w_taken_p0 = (i_ex_rs1 != i_ex_rs2);
        F3_BLT:  w_taken_p0 = (w_rs1_s <  w_rs2_s);
        F3_BGE:  w_taken_p0 = (w_rs1_s >= w_rs2_s);
        F3_BLTU: w_taken_p0 = (i_ex_rs1 <  i_ex_rs2);
        F3_BGEU: w_taken_p0 = (i_ex_rs1 >= i_ex_rs2);
        default: w_taken_p0 = 1'b0;
      endcase
    end else if (w_vld_p0) begin
      w_taken_p0 = 1'b1;
    end
  end

  assign w_mispred_p0 = w_vld_p0 & (w_taken_p0 != i_ex_pred_taken);
  assign o_taken      = w_taken_p0;

  assign w_pf_idx = IDX_W'(bht_idx(32'(i_pf_pc)));
  assign w_ex_idx = IDX_W'(bht_idx(32'(i_ex_pc)));

  bht_counter_array #(
    .ENTRIES (BHT_ENTRIES),
    .CNT_W   (CNT_W)
  ) u_bht (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_idx    (w_pf_idx),
    .o_rd_taken  (o_pf_taken),
    .i_upd_en    (w_br_p0 & ~w_illegal_p0),
    .i_upd_idx   (w_ex_idx),
    .i_upd_taken (w_taken_p0)
  );

  // Resolve -> redirect stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flush_p1         <= 1'b0;
      r_flush_taken_p1   <= 1'b0;
      r_illegal_p1       <= 1'b0;
      r_br_count_p1      <= '0;
      r_mispred_count_p1 <= '0;
    end else begin
      r_flush_p1         <= w_mispred_p0;
      r_flush_taken_p1   <= w_taken_p0;
      r_illegal_p1       <= w_illegal_p0;
      r_br_count_p1      <= sat_inc(r_br_count_p1, w_br_p0);
      r_mispred_count_p1 <= sat_inc(r_mispred_count_p1, w_mispred_p0);
    end
  end

  assign o_flush         = r_flush_p1;
  assign o_flush_taken   = r_flush_taken_p1;
  assign o_illegal_br    = r_illegal_p1;
  assign o_br_count      = r_br_count_p1;
  assign o_mispred_count = r_mispred_count_p1;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Randomised and directed bench for branch_predict_resolve against a
// behavioural model of the direction rules, history table and counters.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pf_pc;
  logic        ex_valid, ex_branch, ex_jump, ex_pred;
  logic [2:0]  ex_f3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc;

  logic        pf_taken, taken, flush, flush_taken, illegal;
  logic [15:0] br_count, mis_count;
  logic        pf_taken2, taken2, flush2, flush_taken2, illegal2;
  logic [1:0]  br_count2, mis_count2;

  int checks = 0;
  int errors = 0;

  int m_bht [64];
  int m_br, m_mis, m_br2, m_mis2;
  bit m_flush, m_flush_taken, m_illegal;

  always #5 clk = ~clk;

  branch_predict_resolve dut (
    .i_clk(clk), .i_rst(rst), .i_pf_pc(pf_pc), .o_pf_taken(pf_taken),
    .i_ex_valid(ex_valid), .i_ex_branch(ex_branch), .i_ex_jump(ex_jump),
    .i_ex_funct3(ex_f3), .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_pc(ex_pc),
    .i_ex_pred_taken(ex_pred), .o_taken(taken), .o_flush(flush),
    .o_flush_taken(flush_taken), .o_illegal_br(illegal),
    .o_br_count(br_count), .o_mispred_count(mis_count)
  );

  branch_predict_resolve #(.PERF_W(2)) dut_p2 (
    .i_clk(clk), .i_rst(rst), .i_pf_pc(pf_pc), .o_pf_taken(pf_taken2),
    .i_ex_valid(ex_valid), .i_ex_branch(ex_branch), .i_ex_jump(ex_jump),
    .i_ex_funct3(ex_f3), .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_pc(ex_pc),
    .i_ex_pred_taken(ex_pred), .o_taken(taken2), .o_flush(flush2),
    .o_flush_taken(flush_taken2), .o_illegal_br(illegal2),
    .o_br_count(br_count2), .o_mispred_count(mis_count2)
  );

  function automatic bit model_taken();
    if (!(ex_valid && (ex_branch || ex_jump))) return 1'b0;
    if (!ex_branch) return 1'b1;
    case (ex_f3)
      3'b000:  return ex_rs1 == ex_rs2;
      3'b001:  return ex_rs1 != ex_rs2;
      3'b100:  return $signed(ex_rs1) <  $signed(ex_rs2);
      3'b101:  return $signed(ex_rs1) >= $signed(ex_rs2);
      3'b110:  return ex_rs1 <  ex_rs2;
      3'b111:  return ex_rs1 >= ex_rs2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return m_bht[(pc >> 2) % 64] >= 2;
  endfunction

  function automatic int sat_add(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0;
    m_flush = 0; m_flush_taken = 0; m_illegal = 0;
  endtask

  task automatic set_ex(input bit v, input bit br, input bit jp, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input bit pred);
    ex_valid = v; ex_branch = br; ex_jump = jp; ex_f3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_pred = pred;
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 3'b000, 0, 0, 0, 0);
  endtask

  // Advance one clock and move the model by the rules, using inputs held before the edge.
  task automatic tick();
    bit e, t, ill, mis, br;
    int idx;
    e   = ex_valid && (ex_branch || ex_jump);
    br  = e && ex_branch;
    t   = model_taken();
    ill = br && (ex_f3 == 3'b010 || ex_f3 == 3'b011);
    mis = e && (t != ex_pred);
    idx = (ex_pc >> 2) % 64;
    @(posedge clk); #1;
    if (rst) begin
      model_reset();
    end else begin
      m_flush = mis; m_flush_taken = t; m_illegal = ill;
      if (br) begin m_br = sat_add(m_br, 65535); m_br2 = sat_add(m_br2, 3); end
      if (mis) begin m_mis = sat_add(m_mis, 65535); m_mis2 = sat_add(m_mis2, 3); end
      if (br && !ill) m_bht[idx] = t ? ((m_bht[idx] >= 3) ? 3 : m_bht[idx] + 1)
                                     : ((m_bht[idx] <= 0) ? 0 : m_bht[idx] - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1; idle(); pf_pc = 32'h100;
    tick(); tick();
    rst = 0; #1;
    checks++; if (pf_taken !== 1'b0) begin errors++; $display("FAIL reset_pf_taken: got %0b want 0", pf_taken); end
    checks++; if (br_count !== 16'd0) begin errors++; $display("FAIL reset_br_count: got %0d want 0", br_count); end
    checks++; if (mis_count !== 16'd0) begin errors++; $display("FAIL reset_mis_count: got %0d want 0", mis_count); end
    checks++; if (flush !== 1'b0 || flush_taken !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got %0b%0b%0b want 000", flush, flush_taken, illegal); end
  endtask

  task automatic test_blt();
    set_ex(1, 1, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 0); #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL blt_taken: got %0b want 1", taken); end
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL blt_flush: got %0b want 1", flush); end
    checks++; if (flush_taken !== 1'b1) begin errors++; $display("FAIL blt_flush_taken: got %0b want 1", flush_taken); end
    set_ex(1, 1, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 0); #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bltu_taken: got %0b want 0", taken); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bltu_noflush: got %0b want 0", flush); end
    checks++; if (br_count !== 16'(m_br)) begin errors++; $display("FAIL blt_br_count: got %0d want %0d", br_count, m_br); end
    idle();
  endtask

  task automatic test_bht_saturate();
    pf_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      set_ex(1, 1, 0, 3'b000, 32'd5, 32'd5, 32'h40, 1); #1;
      checks++; if (pf_taken !== model_pred(32'h40)) begin
        errors++; $display("FAIL bht_preupdate_%0d: got %0b want %0b", k, pf_taken, model_pred(32'h40)); end
      tick();
      checks++; if (pf_taken !== model_pred(32'h40)) begin
        errors++; $display("FAIL bht_postupdate_%0d: got %0b want %0b", k, pf_taken, model_pred(32'h40)); end
    end
    pf_pc = 32'h140; #1;
    checks++; if (pf_taken !== 1'b1) begin errors++; $display("FAIL bht_alias: got %0b want 1", pf_taken); end
    // Saturated at 3: a single not-taken must still predict taken.
    set_ex(1, 1, 0, 3'b001, 32'd5, 32'd5, 32'h40, 1); tick();
    checks++; if (pf_taken !== 1'b1) begin errors++; $display("FAIL bht_sat_hold: got %0b want 1", pf_taken); end
    tick();
    checks++; if (pf_taken !== 1'b0) begin errors++; $display("FAIL bht_dec: got %0b want 0", pf_taken); end
    idle();
  endtask

  task automatic test_illegal();
    int br0;
    br0 = m_br;
    pf_pc = 32'h80;
    set_ex(1, 1, 0, 3'b010, 32'd7, 32'd7, 32'h80, 1); #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL illegal_taken: got %0b want 0", taken); end
    tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %0b want 1", illegal); end
    checks++; if (br_count !== 16'(br0 + 1)) begin errors++; $display("FAIL illegal_br_count: got %0d want %0d", br_count, br0 + 1); end
    set_ex(1, 1, 0, 3'b011, 32'd7, 32'd7, 32'h80, 0); tick(); tick();
    checks++; if (pf_taken !== 1'b0 || m_bht[32] != 1) begin
      errors++; $display("FAIL illegal_bht_unchanged: got %0b want 0", pf_taken); end
    idle(); tick();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle: got %0b want 0", illegal); end
  endtask

  task automatic test_jal();
    pf_pc = 32'h300;
    set_ex(1, 0, 1, 3'b000, 32'd1, 32'd2, 32'h300, 0); #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL jal_taken: got %0b want 1", taken); end
    tick();
    checks++; if (flush !== 1'b1 || flush_taken !== 1'b1) begin
      errors++; $display("FAIL jal_flush: got %0b%0b want 11", flush, flush_taken); end
    for (int k = 0; k < 5; k++) tick();
    idle(); tick();
    checks++; if (pf_taken !== 1'b0) begin errors++; $display("FAIL jal_bht_unchanged: got %0b want 0", pf_taken); end
    checks++; if (mis_count2 !== 2'(m_mis2) || m_mis2 != 3) begin
      errors++; $display("FAIL mis_sat_p2: got %0d want 3", mis_count2); end
    checks++; if (mis_count !== 16'(m_mis)) begin errors++; $display("FAIL mis_count: got %0d want %0d", mis_count, m_mis); end
    checks++; if (br_count2 !== 2'(m_br2)) begin errors++; $display("FAIL br_sat_p2: got %0d want %0d", br_count2, m_br2); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, pc;
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4));
      b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4)));
      pc = 32'($urandom_range(0, 15)) << 2;
      pf_pc = 32'($urandom_range(0, 15)) << 2;
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             3'($urandom_range(0, 7)), a, b, pc, $urandom_range(0, 1) == 1);
      #1;
      checks++; if (taken !== model_taken()) begin
        errors++; $display("FAIL rnd_taken[%0d]: got %0b want %0b", n, taken, model_taken()); end
      checks++; if (pf_taken !== model_pred(pf_pc)) begin
        errors++; $display("FAIL rnd_pf[%0d]: got %0b want %0b", n, pf_taken, model_pred(pf_pc)); end
      tick();
      checks++; if (flush !== m_flush || flush_taken !== m_flush_taken || illegal !== m_illegal) begin
        errors++; $display("FAIL rnd_pulses[%0d]: got %0b%0b%0b want %0b%0b%0b", n,
                           flush, flush_taken, illegal, m_flush, m_flush_taken, m_illegal); end
      checks++; if (br_count !== 16'(m_br) || mis_count !== 16'(m_mis)) begin
        errors++; $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", n, br_count, mis_count, m_br, m_mis); end
      checks++; if (br_count2 !== 2'(m_br2) || mis_count2 !== 2'(m_mis2)) begin
        errors++; $display("FAIL rnd_counts_p2[%0d]: got %0d/%0d want %0d/%0d", n, br_count2, mis_count2, m_br2, m_mis2); end
    end
    idle();
  endtask

  task automatic test_reset_collision();
    pf_pc = 32'h40;
    set_ex(1, 1, 0, 3'b000, 32'd9, 32'd9, 32'h40, 0); tick();
    set_ex(1, 1, 0, 3'b000, 32'd9, 32'd9, 32'h40, 0);
    rst = 1; tick();
    rst = 0; idle(); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstcol_flush: got %0b want 0", flush); end
    checks++; if (br_count !== 16'd0 || mis_count !== 16'd0) begin
      errors++; $display("FAIL rstcol_counts: got %0d/%0d want 0/0", br_count, mis_count); end
    checks++; if (pf_taken !== 1'b0) begin errors++; $display("FAIL rstcol_pf: got %0b want 0", pf_taken); end
  endtask

  initial begin
    model_reset();
    rst = 1; pf_pc = 0; idle();
    test_reset();
    test_blt();
    test_bht_saturate();
    test_illegal();
    test_jal();
    test_random();
    test_reset_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
